fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of one Synchronous_FIFO among N_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_rr_picker.sv | 45 ++++
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and index helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Modulo-n increment by explicit compare, no divider.
  function automatic int next_idx(input int i, input int n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational rotating priority encoder: first active request at or after start.
module fifo_rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand [N];
  logic [N-1:0]  hit;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum       = {1'b0, start} + (IW+1)'(gi);
      assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      assign hit[gi]   = req[cand[gi]];
    end
  endgenerate

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        valid = 1'b1;
        idx   = cand[k];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign onehot[gi] = valid && (idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked sharer of one FIFO write port; zero-latency grants.
// Optional per-requester beat counters when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 6,
  parameter int MAX_BURST  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_data_in
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]      beat_cnt_o
`endif
);

  localparam int IW = idx_w(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e    state_reg, state_next;
  logic [IW-1:0] owner_reg, owner_next;
  logic [IW-1:0] last_reg, last_next;
  logic [BW-1:0] bcnt_reg, bcnt_next;
  logic [BW-1:0] bcnt_inc;

  logic [IW-1:0]         start;
  logic                  pick_valid;
  logic [N_REQ-1:0]      pick_onehot;
  logic [IW-1:0]         pick_idx;
  logic                  lock_hold;
  logic                  win_valid;
  logic [IW-1:0]         win_idx;
  logic                  accept;
  logic [DATA_WIDTH-1:0] beat [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_beat
      assign beat[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // A dropped owner releases in the same cycle, searching from owner+1.
  always_comb begin
    lock_hold = (state_reg == LOCK) && req[owner_reg];
    if (state_reg == LOCK)
      start = IW'(next_idx(int'(owner_reg), N_REQ));
    else
      start = IW'(next_idx(int'(last_reg), N_REQ));
  end

  fifo_rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_picker (
    .req    (req),
    .start  (start),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign win_valid    = lock_hold || pick_valid;
  assign win_idx      = lock_hold ? owner_reg : pick_idx;
  assign accept       = rst_n && win_valid && !fifo_full;
  assign fifo_wr_en   = accept;
  assign fifo_data_in = accept ? beat[win_idx] : '0;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
      assign gnt[gi] = accept && (win_idx == IW'(gi));
    end
  endgenerate

  assign bcnt_inc = bcnt_reg + 1'b1;

  // A full FIFO freezes everything so an interrupted burst resumes intact.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    bcnt_next  = bcnt_reg;
    if (!fifo_full) begin
      if (lock_hold) begin
        if (bcnt_inc == BW'(MAX_BURST)) begin
          state_next = ARB;
          last_next  = owner_reg;
          bcnt_next  = '0;
        end else begin
          bcnt_next  = bcnt_inc;
        end
      end else begin
        if (state_reg == LOCK) begin
          state_next = ARB;
          last_next  = owner_reg;
          bcnt_next  = '0;
        end
        if (accept) begin
          owner_next = win_idx;
          bcnt_next  = BW'(1);
          if (MAX_BURST == 1 || state_reg == LOCK)
            last_next = win_idx;
          state_next = (MAX_BURST == 1) ? ARB : LOCK;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ARB;
      owner_reg <= '0;
      last_reg  <= IW'(N_REQ - 1);
      bcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      bcnt_reg  <= bcnt_next;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!rst_n)
          cnt_reg <= '0;
        else if (gnt[gi] && (cnt_reg != {CNT_W{1'b1}}))
          cnt_reg <= cnt_reg + 1'b1;
      end
      assign beat_cnt_o[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a grant scoreboard and a depth-7 FIFO model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 6;
  localparam int MB = 4;
  localparam int CW = 4;
  localparam int DEPTH = 7;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
`ifdef FIFO_ARB_STATS_EN
  logic [N*CW-1:0] beat_cnt_o;
`endif

  logic force_full;
  logic use_model;
  logic model_clr;
  logic [DW-1:0] mem [DEPTH];
  int model_cnt = 0;
  int viol = 0;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic          wr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] exp_fifo[$];
  int n_pass = 0;
  int n_chk  = 0;
  int stepno = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_cnt_o   (beat_cnt_o)
`endif
  );

  assign fifo_full = use_model ? (model_cnt >= DEPTH) : force_full;

  // Simple FIFO with no reads; any write seen while full is a violation.
  always @(posedge clk) begin
    if (model_clr) begin
      model_cnt <= 0;
    end else if (use_model && fifo_wr_en) begin
      if (model_cnt >= DEPTH) begin
        viol <= viol + 1;
      end else begin
        mem[model_cnt] <= fifo_data_in;
        model_cnt <= model_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // One cycle: drive inputs, queue the expected outcome, compare mid-cycle.
  task automatic step(input logic [N-1:0] r, input logic ff, input int exp_i);
    exp_t e;
    exp_t got;
    req = r;
    force_full = ff;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    e.gnt  = (exp_i < 0) ? '0 : N'(1 << exp_i);
    e.wr   = (exp_i >= 0);
    e.data = (exp_i < 0) ? '0 : req_data[exp_i*DW +: DW];
    sb.push_back(e);
    if (e.wr && use_model) exp_fifo.push_back(e.data);
    @(negedge clk);
    got = sb.pop_front();
    check($sformatf("s%0d gnt", stepno), 32'(gnt), 32'(got.gnt));
    check($sformatf("s%0d wr_en", stepno), 32'(fifo_wr_en), 32'(got.wr));
    check($sformatf("s%0d data", stepno), 32'(fifo_data_in), 32'(got.data));
    $display("step %0d req=%b full=%b gnt=%b wr=%b data=%h", stepno, r, fifo_full, gnt, fifo_wr_en, fifo_data_in);
    stepno++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seq1[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    force_full = 1'b0;
    use_model = 1'b0;
    model_clr = 1'b1;
    @(posedge clk);
    #1;

    // Reset holds grants low even with all requests up.
    step(4'b1111, 1'b0, -1);
    step(4'b1111, 1'b0, -1);
    model_clr = 1'b0;
    rst_n = 1'b1;

    // All requesting: bursts of four, rotating.
    foreach (seq1[i]) step(4'b1111, 1'b0, seq1[i]);

    rst_n = 1'b0;
    step(4'b0101, 1'b0, -1);
    rst_n = 1'b1;

    // Owner 0 drops after two beats; requester 2 takes over with no gap.
    step(4'b0101, 1'b0, 0);
    step(4'b0101, 1'b0, 0);
    step(4'b0100, 1'b0, 2);
    repeat (3) step(4'b0100, 1'b0, 2);
    step(4'b0000, 1'b0, -1);

    // Burst of 1 interrupted by FULL, resumes, then releases to 3.
    step(4'b0010, 1'b0, 1);
    step(4'b0010, 1'b0, 1);
    repeat (3) step(4'b1011, 1'b1, -1);
    step(4'b1011, 1'b0, 1);
    step(4'b1011, 1'b0, 1);
    step(4'b1011, 1'b0, 3);
    step(4'b0000, 1'b0, -1);

    // Fill the depth-7 FIFO from three requesters.
    use_model = 1'b1;
    repeat (4) step(4'b0111, 1'b0, 0);
    repeat (3) step(4'b0111, 1'b0, 1);
    repeat (2) step(4'b0111, 1'b0, -1);
    check("fill count", 32'(model_cnt), 32'(DEPTH));
    check("write while full", 32'(viol), 32'd0);
    check("fifo order depth", 32'(exp_fifo.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && exp_fifo.size() > 0; i++)
      check($sformatf("fifo[%0d]", i), 32'(mem[i]), 32'(exp_fifo.pop_front()));
    use_model = 1'b0;
    step(4'b0000, 1'b0, -1);

    // Reset mid-burst of 3 drops the lock; requester 0 is next.
    step(4'b1000, 1'b0, 3);
    step(4'b1000, 1'b0, 3);
    rst_n = 1'b0;
    step(4'b1001, 1'b0, -1);
    rst_n = 1'b1;
    step(4'b1001, 1'b0, 0);

`ifdef FIFO_ARB_STATS_EN
    rst_n = 1'b0;
    step(4'b0000, 1'b0, -1);
    rst_n = 1'b1;
    repeat (20) step(4'b0100, 1'b0, 2);
    for (int i = 0; i < N; i++)
      check($sformatf("beat_cnt[%0d]", i), 32'(beat_cnt_o[i*CW +: CW]), (i == 2) ? 32'd15 : 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
